// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer slice.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  // $clog2 with a floor of 1 so a 1-bit index still exists for tiny N.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Slot index counter: 0..N-1 with explicit wrap, so non-power-of-2 N works.
module slot_counter
  import tdm_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  assign last = (sel == SEL_W'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sel <= '0;
    else if (clr)   sel <= '0;
    else if (load1) sel <= SEL_W'(1);
    else if (inc)   sel <= last ? '0 : sel + SEL_W'(1);
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM receiver: one bit per valid beat into slot sel,
// completed frame presented on out with a one-cycle out_valid pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [N-1:0]     out,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic             frame_err
);

  tdm_state_t state;
  logic [N-1:0] shreg;
  logic         last;
  logic         clr, load1, inc;

  always_comb begin
    load1 = din_valid & sof;
    clr   = (state == RUN) & din_valid & ~sof & last;
    inc   = (state == RUN) & din_valid & ~sof & ~last;
  end

  slot_counter #(.N(N), .SEL_W(SEL_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load1 (load1),
    .inc   (inc),
    .sel   (sel),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            // Beats without sof are dropped until a frame start is seen.
            if (sof) begin
              shreg[0] <= din;
              state    <= RUN;
            end
          end
          RUN: begin
            if (sof) begin
              frame_err <= 1'b1;
              shreg[0]  <= din;
            end else if (last) begin
              out       <= {din, shreg[N-2:0]};
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              shreg[sel] <= din;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
